// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared states, default timing and timer helpers for the PIC host master
package pic_pkg;

  // Bus cycle phases for register access (SETUP..HOLD) and interrupt acknowledge (ACK1..DONE)
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_ACK1,
    ST_GAP,
    ST_ACK2,
    ST_DONE
  } pic_state_e;

  localparam int DEF_PULSE_CYCLES = 2;
  localparam int DEF_GAP_CYCLES   = 2;
  localparam int TIMER_W          = 4;

  // The timer flags done when it reaches zero, so an N-cycle phase loads N-1
  function automatic logic [TIMER_W-1:0] cycles_to_load(input int cycles);
    return TIMER_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/pic_strobe_timer.sv
// rtl/pic_strobe_timer.sv - loadable 4-bit down-counter timing strobe and gap phases
module pic_strobe_timer
  import pic_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic [TIMER_W-1:0] i_load_val,
  output logic               o_done
);

  logic [TIMER_W-1:0] r_count;

  // Load on phase entry, otherwise count down and park at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/pic_host_master.sv
// rtl/pic_host_master.sv - host-side bus master for 8259-style PIC register access and INTA
module pic_host_master
  import pic_pkg::*;
#(
  parameter int PULSE_CYCLES = DEF_PULSE_CYCLES,
  parameter int GAP_CYCLES   = DEF_GAP_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic       cmd_a0,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  input  logic       int_en,
  input  logic       INT,
  output logic       vec_valid,
  output logic [7:0] vec_data,
  output logic       chip_select,
  output logic       read_Enable,
  output logic       write_Enable,
  output logic       INTA,
  output logic       A0,
  output logic [7:0] data_out,
  output logic       data_oe,
  input  logic [7:0] data_in
);

  localparam logic [TIMER_W-1:0] PULSE_LOAD = cycles_to_load(PULSE_CYCLES);
  localparam logic [TIMER_W-1:0] GAP_LOAD   = cycles_to_load(GAP_CYCLES);

  pic_state_e         r_state;
  pic_state_e         w_state_nxt;
  logic               w_load;
  logic [TIMER_W-1:0] w_load_val;
  logic               w_done;
  logic               w_int_req;
  logic               w_handshake;
  logic               w_access;

  logic               r_write;
  logic               r_a0;
  logic [7:0]         r_data;
  logic [7:0]         r_rsp_data;
  logic [7:0]         r_vec_data;

  // A pending enabled interrupt blocks new commands so the acknowledge always wins
  assign w_int_req   = INT && int_en;
  assign cmd_ready   = (r_state == ST_IDLE) && !w_int_req;
  assign w_handshake = cmd_valid && cmd_ready;
  assign w_access    = (r_state == ST_SETUP) || (r_state == ST_STROBE) || (r_state == ST_HOLD);

  pic_strobe_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_done     (w_done)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and timer load; timed phases load the timer on entry
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_val  = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_int_req) begin
          w_state_nxt = ST_ACK1;
          w_load      = 1'b1;
          w_load_val  = PULSE_LOAD;
        end else if (cmd_valid) begin
          w_state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        w_state_nxt = ST_STROBE;
        w_load      = 1'b1;
        w_load_val  = PULSE_LOAD;
      end
      ST_STROBE: begin
        if (w_done) w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        w_state_nxt = ST_IDLE;
      end
      ST_ACK1: begin
        if (w_done) begin
          w_state_nxt = ST_GAP;
          w_load      = 1'b1;
          w_load_val  = GAP_LOAD;
        end
      end
      ST_GAP: begin
        if (w_done) begin
          w_state_nxt = ST_ACK2;
          w_load      = 1'b1;
          w_load_val  = PULSE_LOAD;
        end
      end
      ST_ACK2: begin
        if (w_done) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Capture the command on handshake; it stays stable for the whole access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write <= 1'b0;
      r_a0    <= 1'b0;
      r_data  <= '0;
    end else if (w_handshake) begin
      r_write <= cmd_write;
      r_a0    <= cmd_a0;
      r_data  <= cmd_data;
    end
  end

  // Sample read data on the final strobe cycle and the vector on the final ACK2 cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_data <= '0;
      r_vec_data <= '0;
    end else begin
      if ((r_state == ST_STROBE) && w_done && !r_write) r_rsp_data <= data_in;
      if ((r_state == ST_ACK2) && w_done)               r_vec_data <= data_in;
    end
  end

  // Bus strobes decode from state only, so reset forces them inactive at once
  always_comb begin
    chip_select  = 1'b1;
    read_Enable  = 1'b1;
    write_Enable = 1'b1;
    INTA         = 1'b1;
    A0           = 1'b0;
    data_oe      = 1'b0;
    data_out     = '0;
    rsp_valid    = 1'b0;
    vec_valid    = 1'b0;
    if (w_access) begin
      chip_select = 1'b0;
      A0          = r_a0;
      data_oe     = r_write;
      data_out    = r_data;
    end
    if (r_state == ST_STROBE) begin
      write_Enable = !r_write;
      read_Enable  = r_write;
    end
    if ((r_state == ST_ACK1) || (r_state == ST_ACK2)) INTA = 1'b0;
    if ((r_state == ST_HOLD) && !r_write)             rsp_valid = 1'b1;
    if (r_state == ST_DONE)                           vec_valid = 1'b1;
  end

  assign rsp_data = r_rsp_data;
  assign vec_data = r_vec_data;

endmodule

// File: tb/tb_pic_host_master.sv
// tb/tb_pic_host_master.sv - directed self-checking bench for pic_host_master
module tb_pic_host_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_write, cmd_a0;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       int_en, INT, vec_valid;
  logic [7:0] vec_data;
  logic       chip_select, read_Enable, write_Enable, INTA, A0;
  logic [7:0] data_out;
  logic       data_oe;
  logic [7:0] data_in;

  logic       cmd_ready2, rsp_valid2, int_en2, INT2, vec_valid2;
  logic [7:0] rsp_data2, vec_data2;
  logic       cs2, re2, we2, inta2, a02, oe2;
  logic [7:0] dout2, data_in2;

  int checks = 0;
  int errors = 0;

  int m_cs, m_we, m_re, m_inta, m_falls, m_rsp, m_vec, m_oe, m_bad_dout, m_a0;
  int m_hs_idx, m_cs_idx, m_vec_idx;
  int m_viol_total = 0;

  always #5 clk = ~clk;

  pic_host_master dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_a0(cmd_a0), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .int_en(int_en), .INT(INT), .vec_valid(vec_valid), .vec_data(vec_data),
    .chip_select(chip_select), .read_Enable(read_Enable), .write_Enable(write_Enable),
    .INTA(INTA), .A0(A0), .data_out(data_out), .data_oe(data_oe), .data_in(data_in)
  );

  pic_host_master #(.PULSE_CYCLES(1), .GAP_CYCLES(15)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(1'b0), .cmd_ready(cmd_ready2), .cmd_write(1'b0),
    .cmd_a0(1'b0), .cmd_data(8'h00),
    .rsp_valid(rsp_valid2), .rsp_data(rsp_data2),
    .int_en(int_en2), .INT(INT2), .vec_valid(vec_valid2), .vec_data(vec_data2),
    .chip_select(cs2), .read_Enable(re2), .write_Enable(we2),
    .INTA(inta2), .A0(a02), .data_out(dout2), .data_oe(oe2), .data_in(data_in2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic mon(input int n, input logic [7:0] exp_dout);
    logic prev_inta;
    logic hs;
    int   nlow;
    m_cs = 0; m_we = 0; m_re = 0; m_inta = 0; m_falls = 0; m_rsp = 0; m_vec = 0;
    m_oe = 0; m_bad_dout = 0; m_a0 = 0; m_hs_idx = -1; m_cs_idx = -1; m_vec_idx = -1;
    prev_inta = 1'b1;
    for (int i = 0; i < n; i++) begin
      #1;
      if (!chip_select) begin
        m_cs++;
        if (m_cs_idx < 0) m_cs_idx = i;
      end
      if (!write_Enable) m_we++;
      if (!read_Enable) m_re++;
      if (!INTA) begin
        m_inta++;
        if (prev_inta) m_falls++;
      end
      prev_inta = INTA;
      if (data_oe) begin
        m_oe++;
        if (data_out !== exp_dout) m_bad_dout++;
      end
      if (A0) m_a0++;
      nlow = (read_Enable ? 0 : 1) + (write_Enable ? 0 : 1) + (INTA ? 0 : 1);
      if (nlow > 1 || (data_oe && (!read_Enable || !INTA))) m_viol_total++;
      if (rsp_valid) m_rsp++;
      if (vec_valid) begin
        m_vec++;
        if (m_vec_idx < 0) m_vec_idx = i;
      end
      hs = cmd_valid && cmd_ready;
      if (hs && m_hs_idx < 0) m_hs_idx = i;
      @(negedge clk);
      if (hs) cmd_valid = 1'b0;
    end
  endtask

  initial begin
    int t_inta2, t_falls2, t_vec2, t_vec2_idx;
    logic prev2;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_a0 = 1'b0; cmd_data = 8'h00;
    int_en = 1'b0; INT = 1'b0; data_in = 8'h00;
    int_en2 = 1'b0; INT2 = 1'b0; data_in2 = 8'h00;
    repeat (2) @(negedge clk);

    // reset values
    chk("rst_strobes", {chip_select, read_Enable, write_Enable, INTA}, 4'b1111);
    chk("rst_a0_oe", {A0, data_oe}, 2'b00);
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_valids", {rsp_valid, vec_valid}, 2'b00);
    chk("rst_rsp_vec_data", {rsp_data, vec_data}, 16'h0000);
    chk("rst_dut2_inta", inta2, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    // write a0=0 data=0x13
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_a0 = 1'b0; cmd_data = 8'h13;
    #1 chk("wr_ready", cmd_ready, 1'b1);
    mon(8, 8'h13);
    chk("wr_hs_idx", m_hs_idx, 0);
    chk("wr_cs_idx", m_cs_idx, 1);
    chk("wr_cs_low", m_cs, 4);
    chk("wr_we_low", m_we, 2);
    chk("wr_re_low", m_re, 0);
    chk("wr_oe_cycles", m_oe, 4);
    chk("wr_bad_dout", m_bad_dout, 0);
    chk("wr_rsp", m_rsp, 0);
    chk("wr_a0", m_a0, 0);

    // read a0=1 with 0xA5 on the bus
    data_in = 8'hA5;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_a0 = 1'b1; cmd_data = 8'hFF;
    mon(8, 8'h00);
    chk("rd_cs_low", m_cs, 4);
    chk("rd_re_low", m_re, 2);
    chk("rd_we_low", m_we, 0);
    chk("rd_rsp_cnt", m_rsp, 1);
    chk("rd_rsp_data", rsp_data, 8'hA5);
    chk("rd_oe_cycles", m_oe, 0);
    chk("rd_a0", m_a0, 4);

    // INT ignored while int_en is low
    INT = 1'b1;
    #1 chk("int_dis_ready", cmd_ready, 1'b1);
    @(negedge clk);
    #1 chk("int_dis_inta", INTA, 1'b1);
    INT = 1'b0;
    @(negedge clk);

    // interrupt acknowledge, INT dropped after ACK1 entry
    data_in = 8'h4B; int_en = 1'b1; INT = 1'b1;
    #1 chk("int_ready", cmd_ready, 1'b0);
    @(negedge clk);
    INT = 1'b0;
    mon(10, 8'h00);
    chk("int_inta_low", m_inta, 4);
    chk("int_falls", m_falls, 2);
    chk("int_vec_idx", m_vec_idx, 6);
    chk("int_vec_cnt", m_vec, 1);
    chk("int_vec_data", vec_data, 8'h4B);
    chk("int_cs_low", m_cs, 0);
    chk("int_oe", m_oe, 0);
    chk("int_rsp_hold", rsp_data, 8'hA5);

    // INT and cmd_valid together: acknowledge first, then the write
    data_in = 8'h6D; INT = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_a0 = 1'b1; cmd_data = 8'h5C;
    #1 chk("col_ready", cmd_ready, 1'b0);
    @(negedge clk);
    INT = 1'b0;
    mon(14, 8'h5C);
    chk("col_vec_idx", m_vec_idx, 6);
    chk("col_hs_idx", m_hs_idx, 7);
    chk("col_cs_idx", m_cs_idx, 8);
    chk("col_we_low", m_we, 2);
    chk("col_oe", m_oe, 4);
    chk("col_bad_dout", m_bad_dout, 0);
    chk("col_a0", m_a0, 4);
    chk("col_vec_data", vec_data, 8'h6D);

    // reset during ACK2
    data_in = 8'h99; INT = 1'b1;
    @(negedge clk);
    INT = 1'b0;
    repeat (4) @(negedge clk);
    #1 chk("rst_ack2_inta_before", INTA, 1'b0);
    rst_n = 1'b0;
    #1 chk("rst_ack2_inta_after", INTA, 1'b1);
    chk("rst_ack2_vec_valid", vec_valid, 1'b0);
    chk("rst_ack2_vec_data", vec_data, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_ack2_idle_ready", cmd_ready, 1'b1);
    mon(6, 8'h00);
    chk("rst_ack2_no_vec", m_vec, 0);
    chk("rst_ack2_no_inta", m_inta, 0);

    chk("strobe_exclusive", m_viol_total, 0);

    // PULSE_CYCLES=1, GAP_CYCLES=15, INT dropped inside the gap
    data_in2 = 8'hC3; int_en2 = 1'b1; INT2 = 1'b1;
    t_inta2 = 0; t_falls2 = 0; t_vec2 = 0; t_vec2_idx = -1; prev2 = 1'b1;
    for (int i = 0; i < 25; i++) begin
      #1;
      if (!inta2) begin
        t_inta2++;
        if (prev2) t_falls2++;
      end
      prev2 = inta2;
      if (vec_valid2) begin
        t_vec2++;
        if (t_vec2_idx < 0) t_vec2_idx = i;
      end
      if (i == 5) INT2 = 1'b0;
      @(negedge clk);
    end
    chk("p1g15_inta_low", t_inta2, 2);
    chk("p1g15_falls", t_falls2, 2);
    chk("p1g15_vec_idx", t_vec2_idx, 18);
    chk("p1g15_vec_cnt", t_vec2, 1);
    chk("p1g15_vec_data", vec_data2, 8'hC3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
